core_state_sequencer: RTL
=========================

Name: core_state_sequencer

Overview:
- Main control FSM of the multi-cycle core. Steps one instruction at a time through fetch-request, fetch-receive, decode, setup, execute, memory and writeback.
- Drives the one-hot phase strobes consumed by the frame write-enable decode logic. Handshakes with instruction and data memory.
- Provides an ack watchdog with a sticky fault state and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for a memory ack before fault; 0 disables the watchdog.
- INSTRET_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; 1 = execute instructions, 0 = stop at next instruction boundary
- imem_ack  in  1  instruction word valid this cycle (1-cycle pulse)
- dmem_ack  in  1  data read data valid / write accepted this cycle
- load  in  1  decoded load flag, stable from SETUP onward
- store  in  1  decoded store flag, stable from SETUP onward
- fetch_RequestState  out  1  phase strobe
- fetch_ReceiveState  out  1  phase strobe
- decodeState  out  1  phase strobe
- setupState  out  1  phase strobe
- executeState  out  1  phase strobe
- memReadState  out  1  phase strobe
- memWriteState  out  1  phase strobe
- writebackState  out  1  phase strobe
- imem_req  out  1  instruction fetch request, 1-cycle pulse
- dmem_req  out  1  data access request, held until dmem_ack
- dmem_write  out  1  qualifies dmem_req as a store
- busy  out  1  1 in any state other than IDLE or FAULT
- fault  out  1  sticky fault indicator
- fault_cause  out  2  00 none, 01 imem timeout, 10 dmem timeout, 11 load+store conflict
- instret  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Reset: synchronous on the rising clk edge with reset=1. State goes to IDLE; all strobes, imem_req, dmem_req, dmem_write, busy and fault are 0; fault_cause=00; instret=0; watchdog=0. Reset overrides any state, including FAULT and pending memory waits.
- Strobes are registered and one-hot; all are 0 in IDLE and FAULT.
- IDLE: go to FETCH_REQ when run=1, else stay.
- FETCH_REQ (1 cycle): imem_req=1; go to FETCH_RECV.
- FETCH_RECV: wait for imem_ack, then go to DECODE.
- DECODE (1 cycle), then SETUP (1 cycle), then EXECUTE.
- EXECUTE (1 cycle), exit priority:
  - load & store: go to FAULT with cause 11.
  - load: go to MEM_READ.
  - store: go to MEM_WRITE.
  - otherwise: go to WRITEBACK.
- MEM_READ: dmem_req=1, dmem_write=0 throughout. Read data must be valid in the dmem_ack cycle, which is the last memReadState cycle. Go to WRITEBACK on dmem_ack.
- MEM_WRITE: dmem_req=1, dmem_write=1 throughout. Go to WRITEBACK on dmem_ack.
- WRITEBACK (1 cycle): instret increments (wraps modulo 2^INSTRET_WIDTH). Go to FETCH_REQ if run=1, else IDLE.
- Deassertion of run mid-instruction has no effect until WRITEBACK.
- Minimum instruction latency: 6 cycles with zero-wait acks (FETCH_REQ, FETCH_RECV with ack, DECODE, SETUP, EXECUTE, WRITEBACK). Add 1 cycle for a load/store with same-cycle ack.
- Watchdog:
  - Counter clears on entry to FETCH_RECV, MEM_READ and MEM_WRITE, and increments each cycle while waiting.
  - When the counter reaches TIMEOUT_CYCLES without an ack, go to FAULT with cause 01 (fetch) or 10 (data).
  - An ack in the same cycle as expiry wins: no fault.
  - TIMEOUT_CYCLES=0: wait indefinitely.
- FAULT: absorbing until reset. fault=1; fault_cause is held; no requests are issued; instret is frozen.
- Acks outside their wait states are ignored and do not alter state.

Decomposition:
- Shared package core_ctrl_pkg: state encoding localparams (IDLE, FETCH_REQ, FETCH_RECV, DECODE, SETUP, EXECUTE, MEM_READ, MEM_WRITE, WRITEBACK, FAULT) and fault-cause constants.
- One sub-module, mem_ack_watchdog: inputs clear, count_en, ack; output expired. Parameterised by TIMEOUT_CYCLES. Instantiated once.

Test Plan:
- ALU instruction: reset, run=1, imem_ack in the FETCH_RECV entry cycle, load=store=0 -> strobes sequence FR, FRx, D, S, E, WB over 6 cycles; instret=1; next cycle fetch_RequestState=1.
- Load with a 3-cycle data wait: load=1, dmem_ack on the 3rd MEM_READ cycle -> memReadState high for exactly 3 cycles, dmem_req high for the same 3 cycles, dmem_write=0, then writebackState; instret increments.
- Store: store=1, dmem_ack 1 cycle after entry -> memWriteState high for 2 cycles with dmem_write=1, then WB.
- Fetch timeout: TIMEOUT_CYCLES=4, imem_ack never arrives -> FAULT after 4 wait cycles; fault=1, fault_cause=01; all strobes 0. Ack at the expiry cycle in a rerun -> no fault, DECODE follows.
- load=store=1 in EXECUTE -> fault_cause=11. A later reset pulse clears fault, cause and instret, and leaves state IDLE.
- run dropped during SETUP -> instruction completes through WB, then IDLE with busy=0. instret preset near 2^32-1 by running (or forced) -> wraps to 0.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core control sequencer: state encoding, fault
// causes and the registered control-output decode.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_REQ  = 4'd1,
    ST_FETCH_RECV = 4'd2,
    ST_DECODE     = 4'd3,
    ST_SETUP      = 4'd4,
    ST_EXECUTE    = 4'd5,
    ST_MEM_READ   = 4'd6,
    ST_MEM_WRITE  = 4'd7,
    ST_WRITEBACK  = 4'd8,
    ST_FAULT      = 4'd9
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_IMEM     = 2'b01;
  localparam logic [1:0] CAUSE_DMEM     = 2'b10;
  localparam logic [1:0] CAUSE_CONFLICT = 2'b11;

  typedef struct packed {
    logic fetch_req;
    logic fetch_recv;
    logic decode;
    logic setup;
    logic execute;
    logic mem_read;
    logic mem_write;
    logic writeback;
    logic imem_req;
    logic dmem_req;
    logic dmem_write;
    logic busy;
    logic fault;
  } ctrl_out_t;

  // Everything the sequencer drives is a pure function of the state it is in.
  function automatic ctrl_out_t ctrl_decode(state_e s);
    ctrl_out_t o;
    o = '0;
    o.busy = (s != ST_IDLE) && (s != ST_FAULT);
    case (s)
      ST_FETCH_REQ:  begin o.fetch_req = 1'b1; o.imem_req = 1'b1; end
      ST_FETCH_RECV: o.fetch_recv = 1'b1;
      ST_DECODE:     o.decode = 1'b1;
      ST_SETUP:      o.setup = 1'b1;
      ST_EXECUTE:    o.execute = 1'b1;
      ST_MEM_READ:   begin o.mem_read = 1'b1; o.dmem_req = 1'b1; end
      ST_MEM_WRITE:  begin o.mem_write = 1'b1; o.dmem_req = 1'b1; o.dmem_write = 1'b1; end
      ST_WRITEBACK:  o.writeback = 1'b1;
      ST_FAULT:      o.fault = 1'b1;
      default:       o.busy = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/core_state_sequencer_if.sv
// Instruction/data memory handshake between the sequencer (master) and memory (slave).
// imem_req is a 1-cycle pulse answered later by a 1-cycle imem_ack; dmem_req (with
// dmem_write) is held until the cycle dmem_ack is seen, which completes the access.
interface core_state_sequencer_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_req;
  logic dmem_write;
  logic dmem_ack;

  modport master (output imem_req, output dmem_req, output dmem_write,
                  input imem_ack, input dmem_ack);
  modport slave  (input imem_req, input dmem_req, input dmem_write,
                  output imem_ack, output dmem_ack);
endinterface

// File: rtl/mem_ack_watchdog.sv
// Wait-cycle counter for memory acks; flags expiry on the TIMEOUT_CYCLES-th
// cycle of an unanswered wait. TIMEOUT_CYCLES=0 never expires.
module mem_ack_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  input  logic ack,
  output logic expired
);
  localparam int CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !ack && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // An ack arriving in the expiry cycle still completes the access.
  assign expired = (TIMEOUT_CYCLES != 0) && count_en && !ack && (cnt_q == LAST);

endmodule

// File: rtl/core_state_sequencer.sv
// Main control FSM of the multi-cycle core: walks each instruction through its
// phases, drives registered one-hot phase strobes and the memory handshakes.
module core_state_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int INSTRET_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     load,
  input  logic                     store,
  core_state_sequencer_if.master   mem,
  output logic                     fetch_RequestState,
  output logic                     fetch_ReceiveState,
  output logic                     decodeState,
  output logic                     setupState,
  output logic                     executeState,
  output logic                     memReadState,
  output logic                     memWriteState,
  output logic                     writebackState,
  output logic                     busy,
  output logic                     fault,
  output logic [1:0]               fault_cause,
  output logic [INSTRET_WIDTH-1:0] instret,
  output state_e                   dbg_state
);

  state_e                   state_q, state_d;
  ctrl_out_t                ctrl_q;
  logic [1:0]               cause_q, cause_d;
  logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

  logic wait_imem, wait_dmem, wd_clear, wd_count, wd_ack, wd_expired;

  assign wait_imem = (state_q == ST_FETCH_RECV);
  assign wait_dmem = (state_q == ST_MEM_READ) || (state_q == ST_MEM_WRITE);
  assign wd_count  = wait_imem || wait_dmem;
  assign wd_ack    = (wait_imem && mem.imem_ack) || (wait_dmem && mem.dmem_ack);
  // Clear in the cycle before each wait state so the first wait cycle sees zero.
  assign wd_clear  = (state_q == ST_FETCH_REQ) || ((state_q == ST_EXECUTE) && (load ^ store));

  mem_ack_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count),
    .ack      (wd_ack),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    case (state_q)
      ST_IDLE:       if (run) state_d = ST_FETCH_REQ;
      ST_FETCH_REQ:  state_d = ST_FETCH_RECV;
      ST_FETCH_RECV: begin
        if (mem.imem_ack) begin
          state_d = ST_DECODE;
        end else if (wd_expired) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_IMEM;
        end
      end
      ST_DECODE:     state_d = ST_SETUP;
      ST_SETUP:      state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (load && store) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_CONFLICT;
        end else if (load) begin
          state_d = ST_MEM_READ;
        end else if (store) begin
          state_d = ST_MEM_WRITE;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM_READ, ST_MEM_WRITE: begin
        if (mem.dmem_ack) begin
          state_d = ST_WRITEBACK;
        end else if (wd_expired) begin
          state_d = ST_FAULT;
          cause_d = CAUSE_DMEM;
        end
      end
      ST_WRITEBACK: begin
        instret_d = instret_q + INSTRET_WIDTH'(1);
        state_d   = run ? ST_FETCH_REQ : ST_IDLE;
      end
      ST_FAULT:      state_d = ST_FAULT;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_decode(state_d);
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  assign fetch_RequestState = ctrl_q.fetch_req;
  assign fetch_ReceiveState = ctrl_q.fetch_recv;
  assign decodeState        = ctrl_q.decode;
  assign setupState         = ctrl_q.setup;
  assign executeState       = ctrl_q.execute;
  assign memReadState       = ctrl_q.mem_read;
  assign memWriteState      = ctrl_q.mem_write;
  assign writebackState     = ctrl_q.writeback;
  assign mem.imem_req       = ctrl_q.imem_req;
  assign mem.dmem_req       = ctrl_q.dmem_req;
  assign mem.dmem_write     = ctrl_q.dmem_write;
  assign busy               = ctrl_q.busy;
  assign fault              = ctrl_q.fault;
  assign fault_cause        = cause_q;
  assign instret            = instret_q;
  assign dbg_state          = state_q;

endmodule
